ascon_ctrl_fsm: RTL and testbench

Control FSM for the ASCON-AEAD128 encryption datapath. It sequences initialization, associated-data absorption, plaintext encryption and finalization. For every state-register update it drives:
- the round index of the permutation;
- the state-register enable;
- the init-load select;
- the Xor_Begin enable, which XORs the data block into S0/S1 ahead of the permutation;
- the permutation bypass;
- the 2-bit Xor_End selector, which sits after the permutation.

It also owns the block handshake with the data source and flags ciphertext and tag capture.

---
 rtl/ascon_ctrl_fsm_if.sv | 35 +++
 rtl/ascon_ctrl_fsm.sv | 174 +++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ascon_ctrl_fsm_if.sv
// Block handshake and datapath control bundle between the ASCON controller and its environment.
// The master side drives start/counts/data_valid; the controller (slave) drives everything else.
interface ascon_ctrl_fsm_if;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RND_W = 4;
    localparam int unsigned XE_W  = 2;

    logic             start_i;
    logic [CNT_W-1:0] ad_blocks_i;
    logic [CNT_W-1:0] pt_blocks_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic [RND_W-1:0] round_o;
    logic             en_reg_state_o;
    logic             init_state_o;
    logic             enable_xb_o;
    logic             bypass_perm_o;
    logic [XE_W-1:0]  enable_xe_o;
    logic             cipher_valid_o;
    logic             en_tag_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
        input  data_ready_o, round_o, en_reg_state_o, init_state_o, enable_xb_o,
               bypass_perm_o, enable_xe_o, cipher_valid_o, en_tag_o, busy_o, done_o
    );

    modport slave (
        input  start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
        output data_ready_o, round_o, en_reg_state_o, init_state_o, enable_xb_o,
               bypass_perm_o, enable_xe_o, cipher_valid_o, en_tag_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-AEAD128 encryption sequencer: init, AD absorption, PT encryption, finalization.
// Outputs decode the registered state/round; WAIT-state outputs also follow data_valid_i.
module ascon_ctrl_fsm (
    input  logic               clock_i,
    input  logic               resetb_i,
    ascon_ctrl_fsm_if.slave    bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RND_W = 4;
    localparam int unsigned XE_W  = 2;

    localparam logic [RND_W-1:0] RND_FIRST = RND_W'(0);
    localparam logic [RND_W-1:0] RND_PB    = RND_W'(4);
    localparam logic [RND_W-1:0] RND_PB1   = RND_W'(5);
    localparam logic [RND_W-1:0] RND_LAST  = RND_W'(11);

    localparam logic [XE_W-1:0] XE_PASS = 2'b00;
    localparam logic [XE_W-1:0] XE_K34  = 2'b01;
    localparam logic [XE_W-1:0] XE_DSEP = 2'b10;
    localparam logic [XE_W-1:0] XE_K23  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_DSEP, S_AD_WAIT, S_AD_PERM,
        S_PT_WAIT, S_PT_PERM, S_FINAL, S_DONE
    } state_t;

    state_t           state, state_n;
    logic [RND_W-1:0] rnd, rnd_n;
    logic [CNT_W-1:0] ad_cnt, ad_cnt_n;
    logic [CNT_W-1:0] pt_cnt, pt_cnt_n;

    logic             ready, en, init, xb, bypass, cv, tag, done;
    logic [RND_W-1:0] round;
    logic [XE_W-1:0]  xe;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state  <= S_IDLE;
            rnd    <= RND_FIRST;
            ad_cnt <= '0;
            pt_cnt <= '0;
        end else begin
            state  <= state_n;
            rnd    <= rnd_n;
            ad_cnt <= ad_cnt_n;
            pt_cnt <= pt_cnt_n;
        end
    end

    // Round counter holds through WAIT stalls; a transfer cycle is round 4 and the counter resumes at 5.
    always_comb begin
        state_n  = state;
        rnd_n    = rnd;
        ad_cnt_n = ad_cnt;
        pt_cnt_n = pt_cnt;
        ready    = 1'b0;
        en       = 1'b0;
        init     = 1'b0;
        xb       = 1'b0;
        bypass   = 1'b0;
        cv       = 1'b0;
        tag      = 1'b0;
        done     = 1'b0;
        xe       = XE_PASS;
        round    = rnd;
        case (state)
            S_IDLE: begin
                round = RND_FIRST;
                if (bus.start_i) begin
                    ad_cnt_n = bus.ad_blocks_i;
                    pt_cnt_n = (bus.pt_blocks_i == '0) ? CNT_W'(1) : bus.pt_blocks_i;
                    rnd_n    = RND_FIRST;
                    state_n  = S_INIT;
                end
            end
            S_INIT: begin
                en   = 1'b1;
                init = (rnd == RND_FIRST);
                if (rnd == RND_LAST) begin
                    xe      = XE_K34;
                    state_n = (ad_cnt != '0) ? S_AD_WAIT : S_DSEP;
                end else begin
                    rnd_n = rnd + RND_W'(1);
                end
            end
            S_DSEP: begin
                en      = 1'b1;
                bypass  = 1'b1;
                xe      = XE_DSEP;
                state_n = S_PT_WAIT;
            end
            S_AD_WAIT: begin
                ready = 1'b1;
                if (bus.data_valid_i) begin
                    round   = RND_PB;
                    xb      = 1'b1;
                    en      = 1'b1;
                    rnd_n   = RND_PB1;
                    state_n = S_AD_PERM;
                end
            end
            S_AD_PERM: begin
                en = 1'b1;
                if (rnd == RND_LAST) begin
                    ad_cnt_n = ad_cnt - CNT_W'(1);
                    if (ad_cnt <= CNT_W'(1)) begin
                        xe      = XE_DSEP;
                        state_n = S_PT_WAIT;
                    end else begin
                        state_n = S_AD_WAIT;
                    end
                end else begin
                    rnd_n = rnd + RND_W'(1);
                end
            end
            S_PT_WAIT: begin
                ready = 1'b1;
                if (bus.data_valid_i) begin
                    xb       = 1'b1;
                    cv       = 1'b1;
                    en       = 1'b1;
                    pt_cnt_n = pt_cnt - CNT_W'(1);
                    if (pt_cnt <= CNT_W'(1)) begin
                        bypass  = 1'b1;
                        xe      = XE_K23;
                        rnd_n   = RND_FIRST;
                        state_n = S_FINAL;
                    end else begin
                        round   = RND_PB;
                        rnd_n   = RND_PB1;
                        state_n = S_PT_PERM;
                    end
                end
            end
            S_PT_PERM: begin
                en = 1'b1;
                if (rnd == RND_LAST) begin
                    state_n = S_PT_WAIT;
                end else begin
                    rnd_n = rnd + RND_W'(1);
                end
            end
            S_FINAL: begin
                en = 1'b1;
                if (rnd == RND_LAST) begin
                    xe      = XE_K34;
                    tag     = 1'b1;
                    state_n = S_DONE;
                end else begin
                    rnd_n = rnd + RND_W'(1);
                end
            end
            S_DONE: begin
                round   = RND_FIRST;
                done    = 1'b1;
                rnd_n   = RND_FIRST;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.data_ready_o   = ready;
    assign bus.round_o        = round;
    assign bus.en_reg_state_o = en;
    assign bus.init_state_o   = init;
    assign bus.enable_xb_o    = xb;
    assign bus.bypass_perm_o  = bypass;
    assign bus.enable_xe_o    = xe;
    assign bus.cipher_valid_o = cv;
    assign bus.en_tag_o       = tag;
    assign bus.busy_o         = (state != S_IDLE);
    assign bus.done_o         = done;
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm: stimulus queues expected per-cycle control vectors,
// a negedge monitor pops one whenever the controller shows any activity and compares.
module tb_ascon_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ascon_ctrl_fsm_if bus ();
    ascon_ctrl_fsm dut (.clock_i(clk), .resetb_i(rst_n), .bus(bus));

    typedef struct packed {
        logic       ready;
        logic [3:0] round;
        logic       en;
        logic       init;
        logic       xb;
        logic       bypass;
        logic [1:0] xe;
        logic       cv;
        logic       tag;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cnt = 0;
    int unsigned c0 = 0;
    int          exp_done = 0;
    bit          done_seen = 1'b0;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic int rel();
        return int'(cnt - c0) + 1;
    endfunction

    function automatic vec_t cur();
        vec_t v;
        v.ready  = bus.data_ready_o;
        v.round  = bus.round_o;
        v.en     = bus.en_reg_state_o;
        v.init   = bus.init_state_o;
        v.xb     = bus.enable_xb_o;
        v.bypass = bus.bypass_perm_o;
        v.xe     = bus.enable_xe_o;
        v.cv     = bus.cipher_valid_o;
        v.tag    = bus.en_tag_o;
        v.done   = bus.done_o;
        v.busy   = bus.busy_o;
        return v;
    endfunction

    function automatic vec_t ev(input logic ready, input logic [3:0] round, input logic en,
                                input logic init, input logic xb, input logic bypass,
                                input logic [1:0] xe, input logic cv, input logic tag,
                                input logic done);
        return {ready, round, en, init, xb, bypass, xe, cv, tag, done, 1'b1};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d got %h required %h", name, rel(), got, want);
        end
    endtask

    // Monitor: any non-idle output activity consumes one expected vector.
    always @(negedge clk) begin
        vec_t a;
        vec_t e;
        a = cur();
        if (rst_n && (a.ready | a.en | a.init | a.xb | a.bypass | (|a.xe) | a.cv | a.tag | a.done)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_activity cycle %0d got %h required none", rel(), a);
            end else begin
                e = exp_q.pop_front();
                check("ctrl_vector", a, e);
            end
            if (a.done) begin
                done_seen = 1'b1;
                check("done_cycle", 16'(rel()), 16'(exp_done));
            end
        end
    end

    // One encryption run; trunc_rst >= 0 aborts with reset at that cycle (during FINAL round trunc_fr).
    task automatic run(input int ad, input int pt, input int stall_blk, input int stall_at,
                       input int stall_len, input int pulse_at, input int trunc_fr,
                       input int trunc_rst, input int done_c);
        int pe;
        int rl;
        bit fin;
        for (int r = 0; r < 12; r++)
            exp_q.push_back(ev(0, 4'(r), 1, r == 0, 0, 0, (r == 11) ? 2'b01 : 2'b00, 0, 0, 0));
        if (ad == 0) exp_q.push_back(ev(0, 4'd11, 1, 0, 0, 1, 2'b10, 0, 0, 0));
        for (int b = 0; b < ad; b++) begin
            if (b == stall_blk)
                for (int s = 0; s < stall_len; s++)
                    exp_q.push_back(ev(1, 4'd11, 0, 0, 0, 0, 2'b00, 0, 0, 0));
            exp_q.push_back(ev(1, 4'd4, 1, 0, 1, 0, 2'b00, 0, 0, 0));
            for (int r = 5; r < 12; r++)
                exp_q.push_back(ev(0, 4'(r), 1, 0, 0, 0,
                                   (r == 11 && b == ad - 1) ? 2'b10 : 2'b00, 0, 0, 0));
        end
        pe = (pt == 0) ? 1 : pt;
        for (int b = 0; b < pe - 1; b++) begin
            exp_q.push_back(ev(1, 4'd4, 1, 0, 1, 0, 2'b00, 1, 0, 0));
            for (int r = 5; r < 12; r++)
                exp_q.push_back(ev(0, 4'(r), 1, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        exp_q.push_back(ev(1, 4'd11, 1, 0, 1, 1, 2'b11, 1, 0, 0));
        for (int r = 0; r < 12 && r < trunc_fr; r++)
            exp_q.push_back(ev(0, 4'(r), 1, 0, 0, 0, (r == 11) ? 2'b01 : 2'b00, 0, r == 11, 0));
        if (trunc_fr > 11) exp_q.push_back(ev(0, 4'd0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        exp_done  = done_c;
        done_seen = 1'b0;

        @(posedge clk); #1;
        bus.start_i      = 1'b1;
        bus.ad_blocks_i  = 4'(ad);
        bus.pt_blocks_i  = 4'(pt);
        bus.data_valid_i = 1'b1;
        @(posedge clk); #1;
        c0 = cnt;
        bus.start_i     = 1'b0;
        bus.ad_blocks_i = 4'(15 - ad);
        bus.pt_blocks_i = 4'(15 - pt);
        fin = 1'b0;
        while (!fin) begin
            rl = rel();
            if (rl == trunc_rst) begin
                rst_n = 1'b0;
                #1;
                check("reset_outputs", cur(), 16'h0);
                check("reset_queue_left", 16'(exp_q.size()), 16'h0);
                exp_q.delete();
                bus.data_valid_i = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                fin = 1'b1;
            end else if (rl > done_c || rl > 400) begin
                check("idle_after_done", cur(), 16'h0);
                check("queue_left", 16'(exp_q.size()), 16'h0);
                check("done_seen", 16'(done_seen), 16'h1);
                exp_q.delete();
                fin = 1'b1;
            end else begin
                bus.data_valid_i = !(rl >= stall_at && rl < stall_at + stall_len);
                bus.start_i      = (rl == pulse_at);
                if (rl == pulse_at) begin
                    bus.ad_blocks_i = 4'd7;
                    bus.pt_blocks_i = 4'd7;
                end
                @(posedge clk); #1;
            end
        end
        bus.start_i      = 1'b0;
        bus.data_valid_i = 1'b0;
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.ad_blocks_i  = '0;
        bus.pt_blocks_i  = '0;
        bus.data_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", cur(), 16'h0);
        rst_n = 1'b1;
        //   ad pt stall_blk at len pulse trunc_fr rst  done
        run(1, 1, -1, -1, 0, -1, 99, -1, 34);
        run(0, 2, -1, -1, 0, -1, 99, -1, 35);
        run(2, 1, -1, -1, 0, -1, 99, -1, 42);
        run(2, 1,  1, 21, 3, -1, 99, -1, 45);
        run(1, 1, -1, -1, 0, 15, 99, -1, 34);
        run(1, 0, -1, -1, 0, -1, 99, -1, 34);
        run(3, 3, -1, -1, 0, -1, 99, -1, 66);
        run(1, 1, -1, -1, 0, -1, 6, 28, 1000);
        run(1, 1, -1, -1, 0, -1, 99, -1, 34);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
